// File: rtl/universal_shifter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : universal_shifter_seq
//  Purpose  : Multi-cycle universal shift register. It shifts one bit per
//             clock for shamt cycles. Rotate modes exist only when the
//             macro UNIVERSAL_ROTATE_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module universal_shifter_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   i,
    input  logic               SR,
    input  logic               SL,
    output logic [WIDTH-1:0]   A,
    output logic               SR_output,
    output logic               SL_output,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] c_MODE_HOLD0 = 3'b000;
    localparam logic [2:0] c_MODE_LSR   = 3'b001;
    localparam logic [2:0] c_MODE_LSL   = 3'b010;
    localparam logic [2:0] c_MODE_LOAD  = 3'b011;
    localparam logic [2:0] c_MODE_ROR   = 3'b100;
    localparam logic [2:0] c_MODE_ROL   = 3'b101;
    localparam logic [2:0] c_MODE_ASR   = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [2:0]         r_mode;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic               r_sr_out;
    logic               r_sl_out;

    logic               w_is_shift_mode;
    logic               w_accept_shift;
    logic               w_accept_load;
    logic               w_last_step;
    logic [WIDTH-1:0]   w_step_a;
    logic               w_sr_cap;
    logic               w_sl_cap;

    // Modes that need SHIFT cycles. Rotates count as hold when disabled.
    always_comb begin
        w_is_shift_mode = 1'b0;
        case (mode)
            c_MODE_LSR,
            c_MODE_LSL,
            c_MODE_ASR:  w_is_shift_mode = 1'b1;
`ifdef UNIVERSAL_ROTATE_EN
            c_MODE_ROR,
            c_MODE_ROL:  w_is_shift_mode = 1'b1;
`endif
            default:     w_is_shift_mode = 1'b0;
        endcase
    end

    assign w_accept_shift = (r_state == IDLE) && start && w_is_shift_mode
                            && (shamt != '0);
    assign w_accept_load  = (r_state == IDLE) && start && (mode == c_MODE_LOAD);
    assign w_last_step    = (r_cnt == SHAMT_W'(1));

    // A single-bit step of the latched operation, using live SR/SL.
    always_comb begin
        w_step_a = r_a;
        w_sr_cap = 1'b0;
        w_sl_cap = 1'b0;
        case (r_mode)
            c_MODE_LSR: begin
                w_step_a = {SR, r_a[WIDTH-1:1]};
                w_sr_cap = 1'b1;
            end
            c_MODE_LSL: begin
                w_step_a = {r_a[WIDTH-2:0], SL};
                w_sl_cap = 1'b1;
            end
`ifdef UNIVERSAL_ROTATE_EN
            c_MODE_ROR: begin
                w_step_a = {r_a[0], r_a[WIDTH-1:1]};
                w_sr_cap = 1'b1;
            end
            c_MODE_ROL: begin
                w_step_a = {r_a[WIDTH-2:0], r_a[WIDTH-1]};
                w_sl_cap = 1'b1;
            end
`endif
            c_MODE_ASR: begin
                w_step_a = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
                w_sr_cap = 1'b1;
            end
            default: begin
                w_step_a = r_a;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept_shift) begin
                    w_state_nxt = SHIFT;
                end else if (start) begin
                    w_state_nxt = DONE;
                end
            end
            SHIFT: begin
                if (w_last_step) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode   <= c_MODE_HOLD0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_sr_out <= 1'b0;
            r_sl_out <= 1'b0;
        end else begin
            if (w_accept_shift) begin
                r_mode <= mode;
                r_cnt  <= shamt;
            end else if (w_accept_load) begin
                r_a <= i;
            end else if (r_state == SHIFT) begin
                r_a   <= w_step_a;
                r_cnt <= r_cnt - SHAMT_W'(1);
                if (w_sr_cap) begin
                    r_sr_out <= r_a[0];
                end
                if (w_sl_cap) begin
                    r_sl_out <= r_a[WIDTH-1];
                end
            end
        end
    end

    assign A         = r_a;
    assign SR_output = r_sr_out;
    assign SL_output = r_sl_out;
    assign busy      = (r_state == SHIFT);
    assign done      = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_universal_shifter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_universal_shifter_seq
//  Purpose  : Directed self-checking bench for universal_shifter_seq
//             (WIDTH=8, SHAMT_W=4). It covers the optional UNIVERSAL_ROTATE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_universal_shifter_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] mode;
    logic [3:0] shamt;
    logic [7:0] i;
    logic       SR;
    logic       SL;
    logic [7:0] A;
    logic       SR_output;
    logic       SL_output;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    universal_shifter_seq #(
        .WIDTH   (8),
        .SHAMT_W (4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .shamt     (shamt),
        .i         (i),
        .SR        (SR),
        .SL        (SL),
        .A         (A),
        .SR_output (SR_output),
        .SL_output (SL_output),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        mode  = 3'b000;
        shamt = 4'd0;
        i     = 8'h00;
        SR    = 1'b0;
        SL    = 1'b0;
        #2;
        chk("rst_A", 32'(A), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_srout", 32'(SR_output), 32'h0);
        chk("rst_slout", 32'(SL_output), 32'h0);
        tick();
        reset = 1'b1;

        // Parallel load
        start = 1'b1; mode = 3'b011; i = 8'hA5;
        tick();
        chk("load_A", 32'(A), 32'hA5);
        chk("load_done", 32'(done), 32'h1);
        chk("load_busy", 32'(busy), 32'h0);
        start = 1'b0;
        tick();
        chk("load_done_off", 32'(done), 32'h0);
        chk("load_busy_off", 32'(busy), 32'h0);

        // Logical right by 3, SR=1; mode/i changes during SHIFT are ignored
        start = 1'b1; mode = 3'b001; shamt = 4'd3; SR = 1'b1;
        tick();
        chk("lsr_busy0", 32'(busy), 32'h1);
        chk("lsr_A0", 32'(A), 32'hA5);
        start = 1'b0; mode = 3'b011; i = 8'h00; shamt = 4'd0;
        tick();
        chk("lsr_A1", 32'(A), 32'hD2);
        chk("lsr_busy1", 32'(busy), 32'h1);
        tick();
        chk("lsr_A2", 32'(A), 32'hE9);
        chk("lsr_busy2", 32'(busy), 32'h1);
        tick();
        chk("lsr_A3", 32'(A), 32'hF4);
        chk("lsr_busy3", 32'(busy), 32'h0);
        chk("lsr_done", 32'(done), 32'h1);
        chk("lsr_srout", 32'(SR_output), 32'h1);
        tick();
        chk("lsr_idle_done", 32'(done), 32'h0);

        // Rotate left by 1 from 0x81
        start = 1'b1; mode = 3'b011; i = 8'h81;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; mode = 3'b101; shamt = 4'd1;
        tick();
        start = 1'b0;
`ifdef UNIVERSAL_ROTATE_EN
        chk("rol_busy", 32'(busy), 32'h1);
        tick();
        chk("rol_A", 32'(A), 32'h03);
        chk("rol_done", 32'(done), 32'h1);
        chk("rol_slout", 32'(SL_output), 32'h1);
`else
        chk("rol_hold_A", 32'(A), 32'h81);
        chk("rol_hold_done", 32'(done), 32'h1);
        chk("rol_hold_busy", 32'(busy), 32'h0);
`endif
        tick();

        // Arithmetic right by 2 from 0x90, start held high throughout
        start = 1'b1; mode = 3'b011; i = 8'h90;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; mode = 3'b110; shamt = 4'd2;
        tick();
        chk("asr_busy0", 32'(busy), 32'h1);
        mode = 3'b011; i = 8'h55;
        tick();
        chk("asr_A1", 32'(A), 32'hC8);
        chk("asr_busy1", 32'(busy), 32'h1);
        tick();
        chk("asr_A2", 32'(A), 32'hE4);
        chk("asr_done", 32'(done), 32'h1);
        chk("asr_srout", 32'(SR_output), 32'h0);
        tick();
        chk("asr_idle_A", 32'(A), 32'hE4);
        chk("asr_idle_done", 32'(done), 32'h0);
        chk("asr_idle_busy", 32'(busy), 32'h0);
        start = 1'b0;

        // Zero count
        start = 1'b1; mode = 3'b001; shamt = 4'd0;
        tick();
        start = 1'b0;
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_busy", 32'(busy), 32'h0);
        chk("zero_A", 32'(A), 32'hE4);
        tick();

        // Left shift by 2, SL sampled live on each step
        start = 1'b1; mode = 3'b010; shamt = 4'd2; SL = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("lsl_A1", 32'(A), 32'hC9);
        chk("lsl_slout1", 32'(SL_output), 32'h1);
        SL = 1'b0;
        tick();
        chk("lsl_A2", 32'(A), 32'h92);
        chk("lsl_done", 32'(done), 32'h1);
        chk("lsl_slout2", 32'(SL_output), 32'h1);
        tick();

        // Reset in the middle of an 8-step shift
        start = 1'b1; mode = 3'b001; shamt = 4'd8; SR = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_busy_pre", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_A", 32'(A), 32'h00);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_done", 32'(done), 32'h0);
        chk("mid_srout", 32'(SR_output), 32'h0);
        #2;
        reset = 1'b1;
        start = 1'b1; mode = 3'b011; i = 8'h3C;
        tick();
        start = 1'b0;
        chk("post_rst_A", 32'(A), 32'h3C);
        chk("post_rst_done", 32'(done), 32'h1);
        tick();
        chk("post_rst_idle", 32'(done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
